// File: rtl/frame_addr_gen.sv
// Raster address generator: walks an h_active x v_active rectangle and emits
// NUM_CH base-relative pixel addresses per beat over a valid/ready stream.
module frame_addr_gen #(
  parameter int ADDR_W   = 32,
  parameter int NUM_CH   = 3,
  parameter int BPP_LOG2 = 2,
  parameter int X_W      = 12,
  parameter int Y_W      = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [X_W-1:0]           h_active,
  input  logic [Y_W-1:0]           v_active,
  input  logic [ADDR_W-1:0]        line_stride,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  output logic [NUM_CH*ADDR_W-1:0] addr_out,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic                     line_last,
  output logic                     frame_last,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               fsm_state
);

  // Handshake: a beat transfers on a rising edge where addr_valid && addr_ready;
  // once raised, addr_valid and all beat fields hold until that transfer.
  // EMPTY is the single busy cycle an empty frame spends before FIN.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EMPTY = 2'd2, FIN = 2'd3} state_t;

  state_t                  state, state_nxt;
  logic [X_W-1:0]          x, x_nxt, h_q, h_nxt, h_sel;
  logic [Y_W-1:0]          y, y_nxt, v_q, v_nxt, v_sel;
  logic [ADDR_W-1:0]       line_off, off_nxt, stride_q, stride_nxt, pix_off;
  logic [NUM_CH*ADDR_W-1:0] base_q, base_nxt, base_sel, addr_nxt;
  logic                    valid_nxt, ll_nxt, fl_nxt, busy_nxt, done_nxt, load_beat;

  assign fsm_state = state;

  always_comb begin
    state_nxt  = state;
    x_nxt      = x;
    y_nxt      = y;
    off_nxt    = line_off;
    h_nxt      = h_q;
    v_nxt      = v_q;
    stride_nxt = stride_q;
    base_nxt   = base_q;
    addr_nxt   = addr_out;
    valid_nxt  = addr_valid;
    ll_nxt     = line_last;
    fl_nxt     = frame_last;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    load_beat  = 1'b0;
    h_sel      = h_q;
    v_sel      = v_q;
    base_sel   = base_q;
    pix_off    = '0;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start) begin
          h_nxt      = h_active;
          v_nxt      = v_active;
          stride_nxt = line_stride;
          base_nxt   = base_addr;
          h_sel      = h_active;
          v_sel      = v_active;
          base_sel   = base_addr;
          busy_nxt   = 1'b1;
          x_nxt      = '0;
          y_nxt      = '0;
          off_nxt    = '0;
          if (h_active != '0 && v_active != '0) begin
            state_nxt = RUN;
            valid_nxt = 1'b1;
            load_beat = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      RUN: begin
        if (addr_valid && addr_ready) begin
          if (frame_last) begin
            state_nxt = FIN;
            valid_nxt = 1'b0;
            ll_nxt    = 1'b0;
            fl_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            load_beat = 1'b1;
            if (line_last) begin
              x_nxt   = '0;
              y_nxt   = y + Y_W'(1);
              off_nxt = line_off + stride_q;
            end else begin
              x_nxt = x + X_W'(1);
            end
          end
        end
      end
      EMPTY: begin
        state_nxt = FIN;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Next beat is computed from the next counters so outputs stay registered
    // and line wraps cost no bubble.
    if (load_beat) begin
      pix_off = off_nxt + (ADDR_W'(x_nxt) << BPP_LOG2);
      for (int i = 0; i < NUM_CH; i++)
        addr_nxt[i*ADDR_W +: ADDR_W] = base_sel[i*ADDR_W +: ADDR_W] + pix_off;
      ll_nxt = (x_nxt == h_sel - X_W'(1));
      fl_nxt = ll_nxt && (y_nxt == v_sel - Y_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      line_off   <= '0;
      h_q        <= '0;
      v_q        <= '0;
      stride_q   <= '0;
      base_q     <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      line_last  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      line_off   <= off_nxt;
      h_q        <= h_nxt;
      v_q        <= v_nxt;
      stride_q   <= stride_nxt;
      base_q     <= base_nxt;
      addr_out   <= addr_nxt;
      addr_valid <= valid_nxt;
      line_last  <= ll_nxt;
      frame_last <= fl_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Bench for frame_addr_gen: table of frame configs plus hand sequences for
// empty frames, restart-while-busy and asynchronous reset mid-frame.
module tb_frame_addr_gen;
  localparam int ADDR_W = 32;
  localparam int NUM_CH = 3;
  localparam int X_W    = 12;
  localparam int Y_W    = 11;
  localparam int W      = NUM_CH*ADDR_W + 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [X_W-1:0]           h_active = '0;
  logic [Y_W-1:0]           v_active = '0;
  logic [ADDR_W-1:0]        line_stride = '0;
  logic [NUM_CH*ADDR_W-1:0] base_addr = '0;
  logic [NUM_CH*ADDR_W-1:0] addr_out;
  logic                     addr_valid, line_last, frame_last, busy, done;
  logic                     addr_ready = 1'b0;
  logic [1:0]               fsm_state;

  frame_addr_gen dut (
    .clk(clk), .rst(rst_n), .start(start), .h_active(h_active), .v_active(v_active),
    .line_stride(line_stride), .base_addr(base_addr), .addr_out(addr_out),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .line_last(line_last),
    .frame_last(frame_last), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  logic [W-1:0] exp_q[$];

  int beats_frame, done_cnt, busy_cnt, first_valid_cyc, done_cyc, last_acc_cyc, start_cyc;
  logic [31:0] first_a0, last_a0;

  typedef struct {
    logic [X_W-1:0] h;
    logic [Y_W-1:0] v;
    logic [31:0]    stride;
    logic [31:0]    b0, b1, b2;
    int             rnd;
    int             exp_beats;
    logic [31:0]    exp_first, exp_last;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // clock/reset helpers
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    addr_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
  end

  // scoreboard monitor, sampling on the falling edge
  initial begin : monitor
    logic [W-1:0] word, prev_word, exp_w;
    logic         prev_stall;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        word = {addr_out, line_last, frame_last};
        if (prev_stall) chk("stall_hold", {addr_valid, word}, {1'b1, prev_word});
        if (addr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("busy_at_done", busy, 0);
        end
        if (addr_valid && addr_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_beat actual=%0h required=no_beat", word);
          end else begin
            exp_w = exp_q.pop_front();
            chk("beat", word, exp_w);
          end
          if (beats_frame == 0) first_a0 = addr_out[31:0];
          last_a0 = addr_out[31:0];
          beats_frame++;
          last_acc_cyc = cyc;
        end
        prev_stall = addr_valid && !addr_ready;
        prev_word  = word;
      end
    end
  end

  // reference model: rows by multiplication, independent of the accumulator
  task automatic push_model(input int h, input int v, input logic [31:0] stride,
                            input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    logic [31:0] off, px;
    logic        ll, fl;
    for (int yy = 0; yy < v; yy++) begin
      for (int xx = 0; xx < h; xx++) begin
        off = stride * 32'(yy);
        px  = 32'(xx) * 32'd4;
        ll  = (xx == h - 1);
        fl  = ll && (yy == v - 1);
        exp_q.push_back({b2 + off + px, b1 + off + px, b0 + off + px, ll, fl});
      end
    end
  endtask

  task automatic start_frame(input logic [X_W-1:0] h, input logic [Y_W-1:0] v, input logic [31:0] stride,
                             input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    @(posedge clk);
    #1;
    beats_frame = 0; done_cnt = 0; busy_cnt = 0;
    first_valid_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
    first_a0 = '0; last_a0 = '0;
    start_cyc = cyc;
    h_active = h; v_active = v; line_stride = stride;
    base_addr = {b2, b1, b0};
    start = 1'b1;
    push_model(int'(h), int'(v), stride, b0, b1, b2);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) break;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("idle_after", {fsm_state, busy, addr_valid}, 0);
  endtask

  task automatic frame_checks(input int beats, input logic [31:0] fa, input logic [31:0] la);
    chk("beats", beats_frame, beats);
    chk("first_a0", first_a0, fa);
    chk("last_a0", last_a0, la);
    chk("queue_empty", exp_q.size(), 0);
    chk("first_latency", first_valid_cyc - start_cyc, 1);
    chk("done_latency", done_cyc - last_acc_cyc, 1);
  endtask

  initial begin : timeout
    #400000;
    n_fail++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0] = '{12'd4, 11'd2, 32'h20, 32'h1000,     32'h2000, 32'h3000,     0, 8, 32'h1000,     32'h102C};
    vecs[1] = '{12'd4, 11'd2, 32'h20, 32'h1000,     32'h2000, 32'h3000,     1, 8, 32'h1000,     32'h102C};
    vecs[2] = '{12'd4, 11'd1, 32'h40, 32'hFFFFFFF8, 32'h0,    32'h7FFFFFFC, 0, 4, 32'hFFFFFFF8, 32'h4};
    vecs[3] = '{12'd1, 11'd3, 32'h100, 32'h10,      32'h20,   32'h30,       1, 3, 32'h10,       32'h210};
    vecs[4] = '{12'd3, 11'd3, 32'h8,  32'h0,        32'h100,  32'hFFFFFFF0, 1, 9, 32'h0,        32'h18};

    repeat (3) @(negedge clk);
    chk("reset_addr", addr_out, 0);
    chk("reset_flags", {addr_valid, line_last, frame_last, busy, done, fsm_state}, 0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ready_mode = vecs[i].rnd;
      start_frame(vecs[i].h, vecs[i].v, vecs[i].stride, vecs[i].b0, vecs[i].b1, vecs[i].b2);
      wait_done(300);
      frame_checks(vecs[i].exp_beats, vecs[i].exp_first, vecs[i].exp_last);
    end

    // empty frames: one busy cycle, then done, never a beat
    ready_mode = 0;
    start_frame(12'd0, 11'd5, 32'h20, 32'h1000, 32'h2000, 32'h3000);
    wait_done(20);
    chk("empty_h_beats", beats_frame, 0);
    chk("empty_h_no_valid", first_valid_cyc, -1);
    chk("empty_h_done_latency", done_cyc - start_cyc, 2);
    chk("empty_h_busy_cycles", busy_cnt, 1);
    start_frame(12'd7, 11'd0, 32'h20, 32'h1000, 32'h2000, 32'h3000);
    wait_done(20);
    chk("empty_v_beats", beats_frame, 0);
    chk("empty_v_busy_cycles", busy_cnt, 1);

    // second start while running must not disturb the frame
    start_frame(12'd4, 11'd2, 32'h20, 32'h1000, 32'h2000, 32'h3000);
    repeat (3) @(posedge clk);
    #1;
    h_active = 12'd2; v_active = 11'd1;
    base_addr = {32'h9000, 32'h9000, 32'h9000};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
    frame_checks(8, 32'h1000, 32'h102C);

    // asynchronous reset while beat 3 is presented
    start_frame(12'd4, 11'd2, 32'h20, 32'h4000, 32'h5000, 32'h6000);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (beats_frame >= 2) break;
    end
    chk("rst_at_beat3", beats_frame, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_addr", addr_out, 0);
    chk("rst_async_flags", {addr_valid, line_last, frame_last, busy, done, fsm_state}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_held_flags", {addr_valid, busy, done, fsm_state}, 0);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    start_frame(12'd4, 11'd2, 32'h20, 32'hA000, 32'hB000, 32'hC000);
    wait_done(100);
    frame_checks(8, 32'hA000, 32'hA02C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
